// File: rtl/lcd_pkg.sv
// Shared state types, HD44780 command codes and the power-on init ROM
// for the character-LCD stream driver.
package lcd_pkg;

   typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, XFER, EXEC_WAIT, FIX_ADDR} state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD} tx_phase_t;
   typedef enum logic [1:0] {WAIT_CMD, WAIT_CLR, WAIT_WAKE} wait_kind_t;

   typedef struct packed {
      logic [7:0] code;
      logic       single;
      wait_kind_t kind;
   } init_step_t;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_DISP_OFF  = 8'h08;
   localparam logic [7:0] CMD_FS4       = 8'h28;
   localparam logic [7:0] CMD_FS8       = 8'h38;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] LINE1_BASE    = 8'h40;
   localparam logic [7:0] CMD_WAKE      = 8'h30;
   localparam logic [7:0] CMD_WAKE4     = 8'h20;
   localparam logic [7:0] CHAR_NL       = 8'h0A;

   localparam int INIT_LEN   = 9;
   // Wait after the first wake-up, in 1 us ticks (4.1 ms).
   localparam int WAKE_TICKS = 4100;

   // Full 4-bit init sequence; 8-bit mode skips index 3 (the 0x2 nibble).
   function automatic init_step_t init_step(input logic [3:0] idx, input logic bus4);
      init_step_t s;
      s.code   = CMD_WAKE;
      s.single = 1'b1;
      s.kind   = WAIT_CMD;
      case (idx)
         4'd0: s.kind = WAIT_WAKE;
         4'd1, 4'd2: s.kind = WAIT_CMD;
         4'd3: s.code = CMD_WAKE4;
         4'd4: begin s.code = bus4 ? CMD_FS4 : CMD_FS8; s.single = 1'b0; end
         4'd5: begin s.code = CMD_DISP_OFF; s.single = 1'b0; end
         4'd6: begin s.code = CMD_CLEAR; s.single = 1'b0; s.kind = WAIT_CLR; end
         4'd7: begin s.code = CMD_ENTRY; s.single = 1'b0; end
         default: begin s.code = CMD_DISP_ON; s.single = 1'b0; end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lcd_bus_tx.sv
// Drives one LCD write: setup / E-high / hold, one tick each, repeated for the
// low nibble in 4-bit mode. Pulses done after the final hold.
module lcd_bus_tx
   import lcd_pkg::*;
#(
   parameter int BUS_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 start,
   input  logic                 rs,
   input  logic                 single,
   input  logic [7:0]           data,
   output logic                 done,
   output logic                 lcd_rs,
   output logic                 lcd_e,
   output logic [BUS_WIDTH-1:0] lcd_db
);

   tx_phase_t  phase;
   logic [3:0] low_nib;
   logic       second;

   // "single" limits a 4-bit write to the high nibble (init wake-ups).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase   <= TX_IDLE;
         low_nib <= '0;
         second  <= 1'b0;
         done    <= 1'b0;
         lcd_rs  <= 1'b0;
         lcd_e   <= 1'b0;
         lcd_db  <= '0;
      end else begin
         done <= 1'b0;
         case (phase)
            TX_IDLE: begin
               if (start) begin
                  lcd_rs  <= rs;
                  low_nib <= data[3:0];
                  if (BUS_WIDTH == 8) begin
                     lcd_db <= BUS_WIDTH'(data);
                     second <= 1'b0;
                  end else begin
                     lcd_db <= BUS_WIDTH'(data[7:4]);
                     second <= !single;
                  end
                  phase <= TX_SETUP;
               end
            end
            TX_SETUP: begin
               if (tick) begin
                  lcd_e <= 1'b1;
                  phase <= TX_PULSE;
               end
            end
            TX_PULSE: begin
               if (tick) begin
                  lcd_e <= 1'b0;
                  phase <= TX_HOLD;
               end
            end
            TX_HOLD: begin
               if (tick) begin
                  if (second) begin
                     second <= 1'b0;
                     lcd_db <= BUS_WIDTH'(low_nib);
                     phase  <= TX_SETUP;
                  end else begin
                     done  <= 1'b1;
                     phase <= TX_IDLE;
                  end
               end
            end
            default: phase <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_char_stream.sv
// HD44780 character stream driver: power-on init, byte handshake, cursor
// tracking with line wrap / newline and automatic DDRAM address fix-ups.
module lcd_char_stream
   import lcd_pkg::*;
#(
   parameter int BUS_WIDTH = 4,
   parameter int COLS      = 16,
   parameter int ROWS      = 2,
   parameter int TICK_DIV  = 50,
   parameter int PWR_TICKS = 15000,
   parameter int CMD_TICKS = 40,
   parameter int CLR_TICKS = 1600
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   input  logic                 in_is_cmd,
   output logic                 in_ready,
   output logic                 init_done,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_e,
   output logic [BUS_WIDTH-1:0] lcd_db,
   output logic                 cur_row,
   output logic [5:0]           cur_col
);

   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int W1       = (PWR_TICKS > WAKE_TICKS) ? PWR_TICKS : WAKE_TICKS;
   localparam int W2       = (CLR_TICKS > CMD_TICKS) ? CLR_TICKS : CMD_TICKS;
   localparam int WAIT_MAX = (W1 > W2) ? W1 : W2;
   localparam int CNT_W    = $clog2(WAIT_MAX + 1);
   localparam int STEPS    = (BUS_WIDTH == 4) ? INIT_LEN : INIT_LEN - 1;

   function automatic logic [CNT_W-1:0] ticks_for(input wait_kind_t k);
      case (k)
         WAIT_CLR:  return CNT_W'(CLR_TICKS);
         WAIT_WAKE: return CNT_W'(WAKE_TICKS);
         default:   return CNT_W'(CMD_TICKS);
      endcase
   endfunction

   state_t           state;
   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_len;
   logic [3:0]       step;
   logic [3:0]       rom_idx;
   init_step_t       rom_step;
   logic             fix_pending;
   logic             next_row;
   logic             tx_start;
   logic             tx_rs;
   logic             tx_single;
   logic [7:0]       tx_data;
   logic             tx_done;

   assign lcd_rw   = 1'b0;
   assign tick     = (pre == PRE_W'(TICK_DIV - 1));
   assign rom_idx  = (BUS_WIDTH == 8 && step >= 4'd3) ? step + 4'd1 : step;
   assign rom_step = init_step(rom_idx, BUS_WIDTH == 4);
   assign next_row = (ROWS == 2) ? ~cur_row : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pre <= '0;
      else     pre <= tick ? '0 : pre + 1'b1;
   end

   // PWR_WAIT and EXEC_WAIT share one tick counter; wait_len is loaded with the
   // duration the next wait needs when each write is launched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= PWR_WAIT;
         wait_cnt    <= '0;
         wait_len    <= CNT_W'(PWR_TICKS);
         step        <= '0;
         fix_pending <= 1'b0;
         tx_start    <= 1'b0;
         tx_rs       <= 1'b0;
         tx_single   <= 1'b0;
         tx_data     <= '0;
         in_ready    <= 1'b0;
         init_done   <= 1'b0;
         cur_row     <= 1'b0;
         cur_col     <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            PWR_WAIT, EXEC_WAIT: begin
               if (tick) begin
                  if (wait_cnt == wait_len - 1'b1) begin
                     wait_cnt <= '0;
                     if (!init_done)       state <= INIT;
                     else if (fix_pending) state <= FIX_ADDR;
                     else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            INIT: begin
               if (step == 4'(STEPS)) begin
                  init_done <= 1'b1;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tx_start  <= 1'b1;
                  tx_data   <= rom_step.code;
                  tx_rs     <= 1'b0;
                  tx_single <= rom_step.single;
                  wait_len  <= ticks_for(rom_step.kind);
                  step      <= step + 1'b1;
                  state     <= XFER;
               end
            end
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready  <= 1'b0;
                  tx_data   <= in_data;
                  tx_rs     <= !in_is_cmd;
                  tx_single <= 1'b0;
                  wait_len  <= CNT_W'(CMD_TICKS);
                  if (!in_is_cmd && in_data == CHAR_NL) begin
                     cur_row <= next_row;
                     cur_col <= '0;
                     state   <= FIX_ADDR;
                  end else begin
                     tx_start <= 1'b1;
                     state    <= XFER;
                     if (!in_is_cmd) begin
                        if (cur_col == 6'(COLS - 1)) begin
                           cur_col     <= '0;
                           cur_row     <= next_row;
                           fix_pending <= 1'b1;
                        end else begin
                           cur_col <= cur_col + 1'b1;
                        end
                     end else if (in_data inside {CMD_CLEAR, CMD_HOME, CMD_HOME | 8'h01}) begin
                        cur_row  <= 1'b0;
                        cur_col  <= '0;
                        wait_len <= CNT_W'(CLR_TICKS);
                     end else if (in_data[7]) begin
                        cur_row <= in_data[6];
                        cur_col <= in_data[5:0];
                     end
                  end
               end
            end
            XFER: begin
               if (tx_done) state <= EXEC_WAIT;
            end
            FIX_ADDR: begin
               tx_start    <= 1'b1;
               tx_data     <= CMD_SET_DDRAM | (cur_row ? LINE1_BASE : 8'h00);
               tx_rs       <= 1'b0;
               tx_single   <= 1'b0;
               wait_len    <= CNT_W'(CMD_TICKS);
               fix_pending <= 1'b0;
               state       <= XFER;
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end

   lcd_bus_tx #(.BUS_WIDTH(BUS_WIDTH)) u_tx (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .start  (tx_start),
      .rs     (tx_rs),
      .single (tx_single),
      .data   (tx_data),
      .done   (tx_done),
      .lcd_rs (lcd_rs),
      .lcd_e  (lcd_e),
      .lcd_db (lcd_db)
   );

endmodule

// File: tb/tb_lcd_char_stream.sv
// Directed bench: a 4-bit / 4x2 driver for init, cursor and wait checks,
// plus an 8-bit driver for its init sequence and a single character write.
module tb_lcd_char_stream;

   localparam int TICK_DIV  = 2;
   localparam int PWR_TICKS = 20;
   localparam int CMD_TICKS = 4;
   localparam int CLR_TICKS = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       valid4, cmd4, ready4, done4, rs4, rw4, e4, row4;
   logic [7:0] data4;
   logic [3:0] db4;
   logic [5:0] col4;
   logic       valid8, cmd8, ready8, done8, rs8, rw8, e8, row8;
   logic [7:0] data8;
   logic [7:0] db8;
   logic [5:0] col8;

   int checks   = 0;
   int failures = 0;

   logic [8:0] p4[$];
   logic [8:0] p8[$];
   logic       e4_prev = 1'b0;
   logic       e8_prev = 1'b0;

   typedef struct {
      logic       is_cmd;
      logic [7:0] data;
      logic       row;
      logic [5:0] col;
      int         nbytes;
      logic [8:0] last;
   } vec_t;

   vec_t       vecs [14];
   logic [3:0] exp4 [14];
   logic [7:0] exp8 [8];

   lcd_char_stream #(.BUS_WIDTH(4), .COLS(4), .ROWS(2), .TICK_DIV(TICK_DIV),
      .PWR_TICKS(PWR_TICKS), .CMD_TICKS(CMD_TICKS), .CLR_TICKS(CLR_TICKS)) dut4 (
      .clk(clk), .rst(rst), .in_valid(valid4), .in_data(data4), .in_is_cmd(cmd4),
      .in_ready(ready4), .init_done(done4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4),
      .lcd_db(db4), .cur_row(row4), .cur_col(col4));

   lcd_char_stream #(.BUS_WIDTH(8), .COLS(16), .ROWS(2), .TICK_DIV(TICK_DIV),
      .PWR_TICKS(PWR_TICKS), .CMD_TICKS(CMD_TICKS), .CLR_TICKS(CLR_TICKS)) dut8 (
      .clk(clk), .rst(rst), .in_valid(valid8), .in_data(data8), .in_is_cmd(cmd8),
      .in_ready(ready8), .init_done(done8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8),
      .lcd_db(db8), .cur_row(row8), .cur_col(col8));

   // Record {rs, db} at every rising edge of E on either bus.
   always @(negedge clk) begin
      if (e4 && !e4_prev) p4.push_back({rs4, 4'h0, db4});
      if (e8 && !e8_prev) p8.push_back({rs8, db8});
      e4_prev <= e4;
      e8_prev <= e8;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic note_timeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out, got no response, expected one", name);
   endtask

   task automatic wait_ready(input bit use8, input int limit);
      int n = 0;
      while (((use8 ? ready8 : ready4) !== 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) note_timeout("wait_ready");
   endtask

   task automatic wait_init(input int limit);
      int n = 0;
      while (!(done4 === 1'b1 && done8 === 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) note_timeout("init_done");
   endtask

   task automatic apply_stimulus(input bit use8, input logic is_cmd, input logic [7:0] data);
      wait_ready(use8, 2000);
      if (use8) begin valid8 = 1'b1; cmd8 = is_cmd; data8 = data; end
      else      begin valid4 = 1'b1; cmd4 = is_cmd; data4 = data; end
      @(negedge clk);
      valid4 = 1'b0;
      valid8 = 1'b0;
   endtask

   task automatic check_init4();
      check_output("init4_count", p4.size(), 14);
      for (int i = 0; i < 14; i++)
         if (i < p4.size()) check_output($sformatf("init4_pulse%0d", i), p4[i], {5'h0, exp4[i]});
   endtask

   // Cycles from the last falling E to in_ready rising, for one command.
   task automatic measure_wait(input logic [7:0] code, output int cnt);
      int   n = 0;
      logic prev = 1'b0;
      apply_stimulus(1'b0, 1'b1, code);
      cnt = 0;
      while (ready4 !== 1'b1 && n < 2000) begin
         if (!e4 && prev) cnt = 0;
         prev = e4;
         @(negedge clk);
         n++;
         cnt++;
      end
      if (n >= 2000) note_timeout("measure_wait");
   endtask

   initial begin
      int         n;
      int         t_cmd;
      int         t_clr;
      int         first_pulse;
      int         ready_early;
      logic [8:0] last;

      exp4 = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
      exp8 = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
      vecs[0]  = '{1'b0, 8'h41, 1'b0, 6'd1, 1, 9'h141};
      vecs[1]  = '{1'b0, 8'h42, 1'b0, 6'd2, 1, 9'h142};
      vecs[2]  = '{1'b0, 8'h43, 1'b0, 6'd3, 1, 9'h143};
      vecs[3]  = '{1'b0, 8'h44, 1'b1, 6'd0, 2, 9'h0C0};
      vecs[4]  = '{1'b0, 8'h45, 1'b1, 6'd1, 1, 9'h145};
      vecs[5]  = '{1'b0, 8'h0A, 1'b0, 6'd0, 1, 9'h080};
      vecs[6]  = '{1'b1, 8'hC3, 1'b1, 6'd3, 1, 9'h0C3};
      vecs[7]  = '{1'b0, 8'h78, 1'b0, 6'd0, 2, 9'h080};
      vecs[8]  = '{1'b1, 8'h0C, 1'b0, 6'd0, 1, 9'h00C};
      vecs[9]  = '{1'b1, 8'h85, 1'b0, 6'd5, 1, 9'h085};
      vecs[10] = '{1'b1, 8'h02, 1'b0, 6'd0, 1, 9'h002};
      vecs[11] = '{1'b1, 8'hC1, 1'b1, 6'd1, 1, 9'h0C1};
      vecs[12] = '{1'b1, 8'h03, 1'b0, 6'd0, 1, 9'h003};
      vecs[13] = '{1'b0, 8'h0A, 1'b1, 6'd0, 1, 9'h0C0};

      rst = 1'b1;
      valid4 = 1'b0; cmd4 = 1'b0; data4 = 8'h00;
      valid8 = 1'b0; cmd8 = 1'b0; data8 = 8'h00;
      repeat (3) @(negedge clk);
      check_output("reset4_outputs", {e4, rs4, rw4, db4, ready4, done4, row4, col4}, 0);
      check_output("reset8_outputs", {e8, rs8, rw8, db8, ready8, done8, row8, col8}, 0);

      rst = 1'b0;
      p4.delete();
      p8.delete();
      wait_init(20000);
      check_init4();
      check_output("init8_count", p8.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < p8.size()) check_output($sformatf("init8_pulse%0d", i), p8[i], {1'b0, exp8[i]});
      check_output("ready_after_init", {ready4, ready8}, 2'b11);

      p8.delete();
      apply_stimulus(1'b1, 1'b0, 8'h41);
      wait_ready(1'b1, 2000);
      check_output("bus8_char_count", p8.size(), 1);
      if (p8.size() > 0) check_output("bus8_char_value", p8[0], 9'h141);
      check_output("bus8_cursor", {row8, col8}, {1'b0, 6'd1});

      for (int v = 0; v < 14; v++) begin
         p4.delete();
         apply_stimulus(1'b0, vecs[v].is_cmd, vecs[v].data);
         wait_ready(1'b0, 2000);
         n = p4.size();
         last = (n >= 2) ? {p4[n-1][8], p4[n-2][3:0], p4[n-1][3:0]} : 9'h1FF;
         check_output($sformatf("vec%0d_cursor", v), {row4, col4}, {vecs[v].row, vecs[v].col});
         check_output($sformatf("vec%0d_pulses", v), n, 2 * vecs[v].nbytes);
         check_output($sformatf("vec%0d_last", v), last, vecs[v].last);
      end

      measure_wait(8'h0C, t_cmd);
      apply_stimulus(1'b0, 1'b1, 8'hC2);
      wait_ready(1'b0, 2000);
      measure_wait(8'h01, t_clr);
      check_output("clear_wait_delta", t_clr - t_cmd, (CLR_TICKS - CMD_TICKS) * TICK_DIV);
      check_output("clear_wait_min", t_clr >= CLR_TICKS * TICK_DIV, 1);
      check_output("clear_cursor", {row4, col4}, 0);

      apply_stimulus(1'b0, 1'b0, 8'h5A);
      n = 0;
      while (e4 !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) note_timeout("e_high_before_reset");
      #1 rst = 1'b1;
      #1 check_output("reset_mid_e", e4, 1'b0);
      check_output("reset_mid_outputs", {e4, rs4, rw4, db4, ready4, done4, row4, col4}, 0);
      @(negedge clk);
      rst = 1'b0;
      p4.delete();
      valid4 = 1'b1; cmd4 = 1'b0; data4 = 8'h41;
      n = 0;
      first_pulse = -1;
      ready_early = 0;
      while (done4 !== 1'b1 && n < 20000) begin
         if (ready4 === 1'b1) ready_early++;
         if (first_pulse < 0 && p4.size() > 0) first_pulse = n;
         @(negedge clk);
         n++;
      end
      valid4 = 1'b0;
      if (n >= 20000) note_timeout("reinit_done");
      check_output("no_ready_during_init", ready_early, 0);
      check_output("pwr_wait_restarted", first_pulse >= PWR_TICKS * TICK_DIV, 1);
      check_init4();
      repeat (20) @(negedge clk);
      check_output("no_handshake_queued", p4.size(), 14);
      check_output("ready_idle_after_reinit", {ready4, row4, col4}, {1'b1, 1'b0, 6'd0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
